// File: rtl/mult_seq_pkg.sv
// rtl/mult_seq_pkg.sv - shared types, default width and parity helper for the multiplier request sequencer
package mult_seq_pkg;

    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_RES,
        RSP
    } state_e;

    typedef struct packed {
        logic res_par;
        logic arg;
        logic timeout;
    } rsp_flags_t;

    // Operands are zero-extended before the call, which leaves the parity unchanged
    function automatic logic even_par(input logic [63:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/mult_req_sequencer_if.sv
// rtl/mult_req_sequencer_if.sv - command/response streams and multiplier req/ack bus of the sequencer
interface mult_req_sequencer_if #(
    parameter int DATA_W = mult_seq_pkg::DATA_W
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [DATA_W-1:0]     cmd_a;
    logic [DATA_W-1:0]     cmd_b;
    logic                  cmd_inj_a;
    logic                  cmd_inj_b;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [2*DATA_W-1:0]   rsp_result;
    logic                  rsp_res_par_err;
    logic                  rsp_arg_err;
    logic                  rsp_timeout;

    logic                  req;
    logic [DATA_W-1:0]     arg_a;
    logic [DATA_W-1:0]     arg_b;
    logic                  arg_a_parity;
    logic                  arg_b_parity;
    logic                  ack;
    logic [2*DATA_W-1:0]   result;
    logic                  result_parity;
    logic                  result_rdy;
    logic                  arg_parity_error;

    modport master (
        input  cmd_valid, cmd_a, cmd_b, cmd_inj_a, cmd_inj_b,
        output cmd_ready,
        output rsp_valid, rsp_result, rsp_res_par_err, rsp_arg_err, rsp_timeout,
        input  rsp_ready,
        output req, arg_a, arg_b, arg_a_parity, arg_b_parity,
        input  ack, result, result_parity, result_rdy, arg_parity_error
    );

    modport slave (
        output cmd_valid, cmd_a, cmd_b, cmd_inj_a, cmd_inj_b,
        input  cmd_ready,
        input  rsp_valid, rsp_result, rsp_res_par_err, rsp_arg_err, rsp_timeout,
        output rsp_ready,
        input  req, arg_a, arg_b, arg_a_parity, arg_b_parity,
        output ack, result, result_parity, result_rdy, arg_parity_error
    );

endinterface

// File: rtl/mult_seq_timer.sv
// rtl/mult_seq_timer.sv - saturating wait counter that flags expiry on its last count
module mult_seq_timer #(
    parameter int TIMEOUT = 64,
    localparam int CNT_W  = $clog2(TIMEOUT)
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (enable && cnt != LAST) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expire = enable && (cnt == LAST);

endmodule

// File: rtl/mult_req_sequencer.sv
// rtl/mult_req_sequencer.sv - drives one multiplier transaction per command and returns product plus error flags
module mult_req_sequencer
    import mult_seq_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    mult_req_sequencer_if.master bus
);
    localparam rsp_flags_t TIMEOUT_FLAGS = '{res_par: 1'b0, arg: 1'b0, timeout: 1'b1};

    state_e     state;
    rsp_flags_t flags;
    rsp_flags_t event_flags;
    logic       timer_clear;
    logic       timer_enable;
    logic       expire;

    // A reported argument fault explains any bad result parity, so it masks the result error
    assign event_flags = '{
        res_par: (bus.result_parity != even_par(64'(bus.result))) && !bus.arg_parity_error,
        arg:     bus.arg_parity_error,
        timeout: 1'b0
    };

    assign timer_clear  = (state == IDLE) || (state == RSP) || (state == REQ && bus.ack);
    assign timer_enable = (state == REQ) || (state == WAIT_RES);

    mult_seq_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (timer_clear),
        .enable (timer_enable),
        .expire (expire)
    );

    assign bus.rsp_res_par_err = flags.res_par;
    assign bus.rsp_arg_err     = flags.arg;
    assign bus.rsp_timeout     = flags.timeout;

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            bus.cmd_ready    <= 1'b0;
            bus.rsp_valid    <= 1'b0;
            bus.rsp_result   <= '0;
            flags            <= '0;
            bus.req          <= 1'b0;
            bus.arg_a        <= '0;
            bus.arg_b        <= '0;
            bus.arg_a_parity <= 1'b0;
            bus.arg_b_parity <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cmd_ready && bus.cmd_valid) begin
                        bus.cmd_ready    <= 1'b0;
                        bus.req          <= 1'b1;
                        bus.arg_a        <= bus.cmd_a;
                        bus.arg_b        <= bus.cmd_b;
                        bus.arg_a_parity <= even_par(64'(bus.cmd_a)) ^ bus.cmd_inj_a;
                        bus.arg_b_parity <= even_par(64'(bus.cmd_b)) ^ bus.cmd_inj_b;
                        state            <= REQ;
                    end else begin
                        bus.cmd_ready <= 1'b1;
                    end
                end
                REQ: begin
                    if (bus.ack) begin
                        bus.req <= 1'b0;
                        if (bus.result_rdy) begin
                            bus.rsp_result <= bus.result;
                            flags          <= event_flags;
                            bus.rsp_valid  <= 1'b1;
                            state          <= RSP;
                        end else begin
                            state <= WAIT_RES;
                        end
                    end else if (expire) begin
                        bus.req        <= 1'b0;
                        bus.rsp_result <= '0;
                        flags          <= TIMEOUT_FLAGS;
                        bus.rsp_valid  <= 1'b1;
                        state          <= RSP;
                    end
                end
                WAIT_RES: begin
                    if (bus.result_rdy) begin
                        bus.rsp_result <= bus.result;
                        flags          <= event_flags;
                        bus.rsp_valid  <= 1'b1;
                        state          <= RSP;
                    end else if (expire) begin
                        bus.rsp_result <= '0;
                        flags          <= TIMEOUT_FLAGS;
                        bus.rsp_valid  <= 1'b1;
                        state          <= RSP;
                    end
                end
                RSP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        bus.cmd_ready <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_req_sequencer.sv
// tb/tb_mult_req_sequencer.sv - scoreboard bench for mult_req_sequencer
module tb_mult_req_sequencer;

    typedef struct {
        logic [31:0] result;
        logic        res_par;
        logic        arg;
        logic        timeout;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    mult_req_sequencer_if bus ();

    mult_req_sequencer #(.TIMEOUT(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && bus.rsp_valid && bus.rsp_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected got result=%h", bus.rsp_result);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if ({bus.rsp_result, bus.rsp_res_par_err, bus.rsp_arg_err, bus.rsp_timeout} !==
                    {e.result, e.res_par, e.arg, e.timeout}) begin
                    errors++;
                    $display("FAIL rsp_data got %h/%b%b%b want %h/%b%b%b",
                             bus.rsp_result, bus.rsp_res_par_err, bus.rsp_arg_err, bus.rsp_timeout,
                             e.result, e.res_par, e.arg, e.timeout);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [15:0] a, input logic [15:0] b, input logic ia, input logic ib);
        int n = 0;
        while (!bus.cmd_ready && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (bus.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL cmd_ready_wait got %b want 1", bus.cmd_ready);
        end
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        bus.cmd_inj_a = ia;
        bus.cmd_inj_b = ib;
        bus.cmd_valid = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
        bus.cmd_inj_a = 1'b0;
        bus.cmd_inj_b = 1'b0;
    endtask

    task automatic mul_pulse(input logic ak, input logic rdy, input logic [31:0] r,
                             input logic p, input logic ae);
        bus.ack              = ak;
        bus.result_rdy       = rdy;
        bus.result           = r;
        bus.result_parity    = p;
        bus.arg_parity_error = ae;
        tick();
        bus.ack              = 1'b0;
        bus.result_rdy       = 1'b0;
        bus.arg_parity_error = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({bus.req, bus.cmd_ready, bus.rsp_valid, bus.rsp_res_par_err, bus.rsp_arg_err,
             bus.rsp_timeout} !== 6'b0 || bus.rsp_result !== 32'h0 || bus.arg_a !== 16'h0) begin
            errors++;
            $display("FAIL reset_state req=%b rdy=%b vld=%b res=%h arg_a=%h want all 0",
                     bus.req, bus.cmd_ready, bus.rsp_valid, bus.rsp_result, bus.arg_a);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (bus.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_cmd_ready got %b want 1", bus.cmd_ready);
        end
    endtask

    task automatic test_basic();
        sb.push_back('{32'hFFFF_FFFA, 1'b0, 1'b0, 1'b0});
        send_cmd(16'd3, 16'hFFFE, 1'b0, 1'b0);
        checks++;
        if (bus.req !== 1'b1 || bus.arg_a !== 16'd3 || bus.arg_b !== 16'hFFFE ||
            bus.arg_a_parity !== 1'b0 || bus.arg_b_parity !== 1'b1 || bus.cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL basic_args req=%b a=%h b=%h pa=%b pb=%b want 1 0003 fffe 0 1",
                     bus.req, bus.arg_a, bus.arg_b, bus.arg_a_parity, bus.arg_b_parity);
        end
        tick();
        checks++;
        if (bus.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_early_valid got %b want 0", bus.rsp_valid);
        end
        mul_pulse(1'b1, 1'b1, 32'hFFFF_FFFA, 1'b0, 1'b0);
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.req !== 1'b0) begin
            errors++;
            $display("FAIL basic_latency vld=%b req=%b want 1 0", bus.rsp_valid, bus.req);
        end
        tick();
    endtask

    task automatic test_arg_err();
        sb.push_back('{32'd15, 1'b0, 1'b1, 1'b0});
        send_cmd(16'd3, 16'd5, 1'b1, 1'b0);
        checks++;
        if (bus.arg_a_parity !== 1'b1 || bus.arg_b_parity !== 1'b0) begin
            errors++;
            $display("FAIL inj_parity pa=%b pb=%b want 1 0", bus.arg_a_parity, bus.arg_b_parity);
        end
        tick();
        mul_pulse(1'b1, 1'b1, 32'd15, 1'b1, 1'b1);
        tick();
    endtask

    task automatic test_res_par();
        sb.push_back('{32'd49, 1'b1, 1'b0, 1'b0});
        send_cmd(16'd7, 16'd7, 1'b0, 1'b0);
        tick();
        mul_pulse(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
        checks++;
        if (bus.req !== 1'b0 || bus.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL wait_res req=%b vld=%b want 0 0", bus.req, bus.rsp_valid);
        end
        mul_pulse(1'b0, 1'b1, 32'd49, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_timeout();
        int n = 0;
        sb.push_back('{32'h0, 1'b0, 1'b0, 1'b1});
        send_cmd(16'd9, 16'd9, 1'b0, 1'b0);
        while (bus.req && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (n != 64 || bus.rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL ack_timeout req_cycles=%0d vld=%b want 64 1", n, bus.rsp_valid);
        end
        tick();
        mul_pulse(1'b1, 1'b1, 32'h1234, 1'b1, 1'b0);
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.req !== 1'b0 || bus.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL stray_idle vld=%b req=%b rdy=%b want 0 0 1",
                     bus.rsp_valid, bus.req, bus.cmd_ready);
        end
        sb.push_back('{32'h0, 1'b0, 1'b0, 1'b1});
        send_cmd(16'd4, 16'd4, 1'b0, 1'b0);
        tick();
        mul_pulse(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
        n = 0;
        while (!bus.rsp_valid && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (n != 64) begin
            errors++;
            $display("FAIL res_timeout wait_cycles=%0d want 64", n);
        end
        tick();
        sb.push_back('{32'hFFFF_FFEC, 1'b0, 1'b0, 1'b0});
        send_cmd(16'hFFFC, 16'd5, 1'b0, 1'b0);
        tick();
        mul_pulse(1'b1, 1'b1, 32'hFFFF_FFEC, 1'b1, 1'b0);
        checks++;
        if (bus.rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL after_timeout_vld got %b want 1", bus.rsp_valid);
        end
        tick();
    endtask

    task automatic test_backpressure();
        logic ok = 1'b1;
        bus.rsp_ready = 1'b0;
        sb.push_back('{32'd6, 1'b0, 1'b0, 1'b0});
        send_cmd(16'd2, 16'd3, 1'b0, 1'b0);
        tick();
        mul_pulse(1'b1, 1'b1, 32'd6, 1'b0, 1'b0);
        sb.push_back('{32'd1, 1'b0, 1'b0, 1'b0});
        bus.cmd_a     = 16'hFFFF;
        bus.cmd_b     = 16'hFFFF;
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (bus.cmd_ready !== 1'b0 || bus.rsp_valid !== 1'b1 || bus.rsp_result !== 32'd6 ||
                bus.rsp_timeout !== 1'b0)
                ok = 1'b0;
            tick();
        end
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL hold_stable rdy=%b vld=%b res=%h want 0 1 6",
                     bus.cmd_ready, bus.rsp_valid, bus.rsp_result);
        end
        bus.rsp_ready = 1'b1;
        tick();
        checks++;
        if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL release rdy=%b vld=%b want 1 0", bus.cmd_ready, bus.rsp_valid);
        end
        tick();
        bus.cmd_valid = 1'b0;
        checks++;
        if (bus.req !== 1'b1 || bus.cmd_ready !== 1'b0 || bus.arg_a !== 16'hFFFF) begin
            errors++;
            $display("FAIL next_accept req=%b rdy=%b a=%h want 1 0 ffff",
                     bus.req, bus.cmd_ready, bus.arg_a);
        end
        tick();
        mul_pulse(1'b1, 1'b1, 32'd1, 1'b1, 1'b0);
        tick();
    endtask

    task automatic test_mid_reset();
        send_cmd(16'd5, 16'd6, 1'b0, 1'b0);
        tick();
        mul_pulse(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (bus.req !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset req=%b vld=%b rdy=%b want 0 0 0",
                     bus.req, bus.rsp_valid, bus.cmd_ready);
        end
        mul_pulse(1'b0, 1'b1, 32'd30, 1'b0, 1'b0);
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL late_rdy vld=%b rdy=%b want 0 1", bus.rsp_valid, bus.cmd_ready);
        end
        sb.push_back('{32'hFFFF_FFE2, 1'b0, 1'b0, 1'b0});
        send_cmd(16'd10, 16'hFFFD, 1'b0, 1'b0);
        tick();
        mul_pulse(1'b1, 1'b1, 32'hFFFF_FFE2, 1'b0, 1'b0);
        tick();
    endtask

    initial begin
        bus.cmd_valid        = 1'b0;
        bus.cmd_a            = '0;
        bus.cmd_b            = '0;
        bus.cmd_inj_a        = 1'b0;
        bus.cmd_inj_b        = 1'b0;
        bus.rsp_ready        = 1'b1;
        bus.ack              = 1'b0;
        bus.result           = '0;
        bus.result_parity    = 1'b0;
        bus.result_rdy       = 1'b0;
        bus.arg_parity_error = 1'b0;
        test_reset();
        test_basic();
        test_arg_err();
        test_res_par();
        test_timeout();
        test_backpressure();
        test_mid_reset();
        tick();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left=%0d want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
